// File: rtl/riscv_fetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
// Core-wide widths come from the riscv_configs macros (XLEN, RISCV_INSTR_W, RISCV_PC_STEP,
// RISCV_NOP). Each one is given a default here so that this package compiles on its own.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RISCV_INSTR_W
`define RISCV_INSTR_W 32
`endif
`ifndef RISCV_PC_STEP
`define RISCV_PC_STEP 4
`endif
`ifndef RISCV_NOP
`define RISCV_NOP 32'h0000_0013
`endif

package riscv_fetch_unit_pkg;
  localparam int unsigned Xlen   = `XLEN;
  localparam int unsigned InstrW = `RISCV_INSTR_W;
  localparam int unsigned PcStep = `RISCV_PC_STEP;

  // One fetch-buffer entry as presented to decode.
  typedef struct packed {
    logic [Xlen-1:0]   pc;
    logic [InstrW-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and
// execute redirect. The master modport belongs to the fetch unit. The slave modport belongs to
// the memory/pipeline side.
// When RISCV_FETCH_MISALIGN_EN is defined, the bundle also carries the misaligned-target flag
// and the offending target.
interface riscv_fetch_unit_if;
  import riscv_fetch_unit_pkg::*;

  logic              o_imem_req;
  logic [Xlen-1:0]   o_imem_addr;
  logic              i_imem_ready;
  logic              i_imem_rvalid;
  logic [InstrW-1:0] i_imem_rdata;
  logic              o_if_valid;
  logic [Xlen-1:0]   o_if_pc;
  logic [InstrW-1:0] o_if_instr;
  logic              i_id_ready;
  logic              i_redirect;
  logic [Xlen-1:0]   i_redirect_pc;
`ifdef RISCV_FETCH_MISALIGN_EN
  logic              o_fetch_misalign;
  logic [Xlen-1:0]   o_fetch_misalign_pc;
`endif

  modport master (
    output o_imem_req, o_imem_addr, o_if_valid, o_if_pc, o_if_instr,
`ifdef RISCV_FETCH_MISALIGN_EN
    output o_fetch_misalign, o_fetch_misalign_pc,
`endif
    input  i_imem_ready, i_imem_rvalid, i_imem_rdata, i_id_ready, i_redirect, i_redirect_pc
  );

  modport slave (
    input  o_imem_req, o_imem_addr, o_if_valid, o_if_pc, o_if_instr,
`ifdef RISCV_FETCH_MISALIGN_EN
    input  o_fetch_misalign, o_fetch_misalign_pc,
`endif
    output i_imem_ready, i_imem_rvalid, i_imem_rdata, i_id_ready, i_redirect, i_redirect_pc
  );
endinterface

// File: rtl/riscv_fetch_fifo.sv
// Synchronous FIFO with a flush input and an occupancy count output. It holds the fetch buffer
// ({pc,instr}) and the address-tag queue.
// Ports: clk_i/rst_ni clock and asynchronous active-low reset; flush_i empties the FIFO and
//        overrides push/pop; push_i/wdata_i write; pop_i removes the head; rdata_o is the head
//        (registered storage); count_o is the number of stored entries.
// Depth must be a power of two and at least 2. Push while full is accepted when a pop happens
// in the same cycle.
module riscv_fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full, empty, do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata_i;
        wptr_d        = wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/riscv_fetch_unit.sv
// RV32I instruction-fetch stage. It generates the PC and issues pipelined word requests to
// instruction memory. In-order responses are buffered as {pc,instr} and presented to decode
// through a valid/ready handshake. On a redirect, the unit discards wrong-path fetches that are
// still in flight.
// Ports: i_clk clock; i_rstn asynchronous active-low reset; bus (master modport) carries the
//        imem request/response, the decode handshake and the redirect inputs.
// Optional feature macro: RISCV_FETCH_MISALIGN_EN. It adds the sticky misaligned-target flag
// and stalls fetch after a misaligned redirect. Without it, redirect targets are forced to word
// alignment.
module riscv_fetch_unit
  import riscv_fetch_unit_pkg::*;
#(
  parameter logic [Xlen-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  riscv_fetch_unit_if.master  bus
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SumW = CntW + 2;

  logic [Xlen-1:0] pc_q, pc_d;
  logic [CntW-1:0] drop_q, drop_d;
  logic            started_q, started_d;

  logic [CntW-1:0] fifo_count, tag_count;
  logic [Xlen-1:0] tag_head;
  fetch_entry_t    fifo_wdata, fifo_head;
  logic [SumW-1:0] slots_in_use;
  logic [Xlen-1:0] redirect_target;
  logic            fetch_stop;
  logic            accept, drop_resp, keep_resp, if_valid;

  // The tag queue gets one entry per accepted request. An entry is released by a kept response
  // and cleared by a redirect, so the tag-queue occupancy is the outstanding-request count.
  assign slots_in_use = SumW'(fifo_count) + SumW'(tag_count) + SumW'(drop_q);
  assign bus.o_imem_req  = started_q && !fetch_stop && !bus.i_redirect &&
                           (slots_in_use < SumW'(FIFO_DEPTH));
  assign bus.o_imem_addr = pc_q;

  assign accept    = bus.o_imem_req && bus.i_imem_ready;
  assign drop_resp = bus.i_imem_rvalid && (drop_q != '0);
  assign keep_resp = bus.i_imem_rvalid && (drop_q == '0) && !bus.i_redirect;
  assign if_valid  = (fifo_count != '0);

  assign fifo_wdata = '{pc: tag_head, instr: bus.i_imem_rdata};

  riscv_fetch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (Xlen)
  ) u_tag_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .flush_i (bus.i_redirect),
    .push_i  (accept),
    .wdata_i (pc_q),
    .pop_i   (keep_resp),
    .rdata_o (tag_head),
    .count_o (tag_count)
  );

  riscv_fetch_fifo #(
    .Depth (FIFO_DEPTH),
    .Width ($bits(fetch_entry_t))
  ) u_data_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rstn),
    .flush_i (bus.i_redirect),
    .push_i  (keep_resp),
    .wdata_i (fifo_wdata),
    .pop_i   (if_valid && bus.i_id_ready && !bus.i_redirect),
    .rdata_o (fifo_head),
    .count_o (fifo_count)
  );

  always_comb begin
    pc_d      = pc_q;
    drop_d    = drop_q;
    started_d = 1'b1;
    if (bus.i_redirect) begin
      pc_d   = redirect_target;
      // A same-cycle response retires one in-flight fetch. The remaining ones become drops.
      drop_d = drop_q + tag_count - CntW'(bus.i_imem_rvalid);
    end else begin
      if (accept) pc_d = pc_q + Xlen'(PcStep);
      if (drop_resp) drop_d = drop_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q      <= RESET_PC;
      drop_q    <= '0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      drop_q    <= drop_d;
      started_q <= started_d;
    end
  end

  assign bus.o_if_valid = if_valid;
  assign bus.o_if_pc    = if_valid ? fifo_head.pc : '0;
  assign bus.o_if_instr = if_valid ? fifo_head.instr : '0;

`ifdef RISCV_FETCH_MISALIGN_EN
  logic            misalign_q, misalign_d;
  logic [Xlen-1:0] misalign_pc_q, misalign_pc_d;

  always_comb begin
    misalign_d    = misalign_q;
    misalign_pc_d = misalign_pc_q;
    if (bus.i_redirect) begin
      misalign_d = |bus.i_redirect_pc[1:0];
      if (misalign_d) misalign_pc_d = bus.i_redirect_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      misalign_q    <= 1'b0;
      misalign_pc_q <= '0;
    end else begin
      misalign_q    <= misalign_d;
      misalign_pc_q <= misalign_pc_d;
    end
  end

  assign redirect_target         = bus.i_redirect_pc;
  assign fetch_stop              = misalign_q;
  assign bus.o_fetch_misalign    = misalign_q;
  assign bus.o_fetch_misalign_pc = misalign_pc_q;
`else
  assign redirect_target = bus.i_redirect_pc & ~Xlen'(3);
  assign fetch_stop      = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit. A fixed-latency, in-order memory model returns
// instr = memf(addr). The reference is the architectural PC stream: decode must see
// consecutive word addresses from RESET_PC, and after each redirect it must see the target.
// Each delivered instruction must equal memf(pc).
module tb_riscv_fetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int unsigned FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  riscv_fetch_unit_if bus ();

  riscv_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0000_0013;
  endfunction

  // Memory model: accepts per ready, answers in order mem_lat cycles after accept.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t       pend_q[$];
  int unsigned mcyc      = 0;
  int unsigned mem_lat   = 1;
  bit          ready_rnd = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q.delete();
      bus.i_imem_ready  <= 1'b0;
      bus.i_imem_rvalid <= 1'b0;
      bus.i_imem_rdata  <= '0;
      mcyc              <= 0;
    end else begin
      mcyc <= mcyc + 1;
      if (bus.o_imem_req && bus.i_imem_ready)
        pend_q.push_back('{addr: bus.o_imem_addr, due: mcyc + mem_lat});
      if (pend_q.size() > 0 && pend_q[0].due <= mcyc + 1) begin
        bus.i_imem_rvalid <= 1'b1;
        bus.i_imem_rdata  <= memf(pend_q[0].addr);
        pend_q.pop_front();
      end else begin
        bus.i_imem_rvalid <= 1'b0;
        bus.i_imem_rdata  <= '0;
      end
      bus.i_imem_ready <= ready_rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: records every instruction decode actually takes. A pop in a redirect cycle is
  // discarded by the pipeline and is not recorded.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int unsigned cyc;
  } got_t;
  got_t        got_q[$];
  int unsigned cyc     = 0;
  int unsigned acc_cnt = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rstn && bus.o_if_valid && bus.i_id_ready && !bus.i_redirect)
      got_q.push_back('{pc: bus.o_if_pc, instr: bus.o_if_instr, cyc: cyc});
    if (rstn && bus.o_imem_req && bus.i_imem_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    bus.i_redirect = 1'b0;
    to_pos();
    to_pos();
    rstn = 1'b1;
    got_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    to_neg();
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++;
      $display("FAIL reset_req: got %b want 0", bus.o_imem_req); end
    checks++; if (bus.o_if_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid: got %b want 0", bus.o_if_valid); end
    checks++; if (bus.o_if_pc !== 32'h0) begin errors++;
      $display("FAIL reset_pc: got %h want 0", bus.o_if_pc); end
    checks++; if (bus.o_if_instr !== 32'h0) begin errors++;
      $display("FAIL reset_instr: got %h want 0", bus.o_if_instr); end
    to_pos();
    rstn = 1'b1;
    to_neg();
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++;
      $display("FAIL first_cycle_req: got %b want 0", bus.o_imem_req); end
    to_pos();
    to_neg();
    checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== RESET_PC) begin errors++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=%h",
               bus.o_imem_req, bus.o_imem_addr, RESET_PC); end
    to_pos();
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    apply_reset();
    repeat (30) to_pos();
    to_neg();
    checks++; if (got_q.size() < 10) begin errors++;
      $display("FAIL stream_count: got %0d want >=10", got_q.size()); end
    exp = RESET_PC;
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i].pc !== exp || got_q[i].instr !== memf(exp)) begin errors++;
        $display("FAIL stream[%0d]: got %h/%h want %h/%h", i, got_q[i].pc, got_q[i].instr,
                 exp, memf(exp)); end
      exp += 32'd4;
    end
    to_pos();
  endtask

  task automatic test_backpressure();
    int unsigned a0;
    logic [31:0] exp;
    bus.i_id_ready = 1'b0;
    apply_reset();
    a0 = acc_cnt;
    repeat (10) to_pos();
    to_neg();
    checks++; if (acc_cnt - a0 !== FIFO_DEPTH) begin errors++;
      $display("FAIL bp_accepts: got %0d want %0d", acc_cnt - a0, FIFO_DEPTH); end
    checks++; if (bus.o_imem_req !== 1'b0) begin errors++;
      $display("FAIL bp_req: got %b want 0", bus.o_imem_req); end
    checks++; if (bus.o_if_valid !== 1'b1 || bus.o_if_pc !== RESET_PC) begin errors++;
      $display("FAIL bp_hold: got v=%b pc=%h want v=1 pc=%h", bus.o_if_valid, bus.o_if_pc,
               RESET_PC); end
    to_pos();
    bus.i_id_ready = 1'b1;
    repeat (12) to_pos();
    to_neg();
    checks++;
    if (got_q.size() < 3) begin errors++;
      $display("FAIL bp_release_count: got %0d want >=3", got_q.size());
    end else if (got_q[1].cyc - got_q[0].cyc !== 1) begin errors++;
      $display("FAIL bp_release_gap: got %0d want 1", got_q[1].cyc - got_q[0].cyc);
    end
    exp = RESET_PC;
    foreach (got_q[i]) begin
      checks++;
      if (got_q[i].pc !== exp || got_q[i].instr !== memf(exp)) begin errors++;
        $display("FAIL bp_seq[%0d]: got %h/%h want %h/%h", i, got_q[i].pc, got_q[i].instr,
                 exp, memf(exp)); end
      exp += 32'd4;
    end
    to_pos();
  endtask

  task automatic test_redirect_drop();
    bit found = 1'b0;
    mem_lat = 3;
    apply_reset();
    for (int i = 0; i < 50 && !found; i++) begin
      if (pend_q.size() + int'(bus.i_imem_rvalid) == 2) found = 1'b1;
      else to_pos();
    end
    checks++; if (!found) begin errors++;
      $display("FAIL drop_setup: got timeout want 2 outstanding"); end
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0100;
    to_neg();
    got_q.delete();
    to_pos();
    bus.i_redirect = 1'b0;
    repeat (20) to_pos();
    to_neg();
    checks++;
    if (got_q.size() < 2) begin errors++;
      $display("FAIL drop_count: got %0d want >=2", got_q.size());
    end else if (got_q[0].pc !== 32'h100 || got_q[1].pc !== 32'h104 ||
                 got_q[0].instr !== memf(32'h100) || got_q[1].instr !== memf(32'h104)) begin
      errors++;
      $display("FAIL drop_seq: got %h,%h want 00000100,00000104", got_q[0].pc, got_q[1].pc);
    end
    mem_lat = 1;
    to_pos();
  endtask

  task automatic test_collide();
    bit found = 1'b0;
    apply_reset();
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.i_imem_rvalid && bus.o_if_valid) found = 1'b1;
      else to_pos();
    end
    checks++; if (!found) begin errors++;
      $display("FAIL collide_setup: got timeout want rvalid&&valid"); end
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0300;
    to_neg();
    got_q.delete();
    to_pos();
    bus.i_redirect = 1'b0;
    to_neg();
    checks++; if (bus.o_if_valid !== 1'b0) begin errors++;
      $display("FAIL collide_flush: got %b want 0", bus.o_if_valid); end
    to_pos();
    to_neg();
    checks++; if (bus.o_if_valid !== 1'b0) begin errors++;
      $display("FAIL collide_lat2: got %b want 0", bus.o_if_valid); end
    to_pos();
    to_neg();
    checks++;
    if (bus.o_if_valid !== 1'b1 || bus.o_if_pc !== 32'h300 ||
        bus.o_if_instr !== memf(32'h300)) begin errors++;
      $display("FAIL collide_lat3: got v=%b pc=%h want v=1 pc=00000300", bus.o_if_valid,
               bus.o_if_pc); end
    to_pos();
  endtask

  task automatic test_async_reset();
    apply_reset();
    repeat (8) to_pos();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.o_imem_req, bus.o_if_valid} !== 2'b00 || bus.o_if_pc !== 32'h0 ||
        bus.o_if_instr !== 32'h0) begin errors++;
      $display("FAIL async_reset: got req=%b v=%b pc=%h instr=%h want all 0", bus.o_imem_req,
               bus.o_if_valid, bus.o_if_pc, bus.o_if_instr); end
    to_pos();
    rstn = 1'b1;
    got_q.delete();
    repeat (12) to_pos();
    to_neg();
    checks++;
    if (got_q.size() < 2) begin errors++;
      $display("FAIL async_restart_count: got %0d want >=2", got_q.size());
    end else if (got_q[0].pc !== RESET_PC || got_q[1].pc !== RESET_PC + 32'd4 ||
                 got_q[0].instr !== memf(RESET_PC)) begin errors++;
      $display("FAIL async_restart: got %h,%h want %h,%h", got_q[0].pc, got_q[1].pc,
               RESET_PC, RESET_PC + 32'd4);
    end
    to_pos();
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    apply_reset();
    repeat (4) to_pos();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'hFFFF_FFF8;
    to_neg();
    got_q.delete();
    to_pos();
    bus.i_redirect = 1'b0;
    repeat (16) to_pos();
    to_neg();
    checks++; if (got_q.size() < 4) begin errors++;
      $display("FAIL wrap_count: got %0d want >=4", got_q.size()); end
    exp = 32'hFFFF_FFF8;
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i].pc !== exp || got_q[i].instr !== memf(exp)) begin errors++;
        $display("FAIL wrap[%0d]: got %h want %h", i, got_q[i].pc, exp); end
      exp += 32'd4;
    end
    to_pos();
  endtask

  task automatic test_misalign();
    int unsigned a0;
    apply_reset();
    repeat (4) to_pos();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0102;
    to_neg();
    got_q.delete();
    to_pos();
    bus.i_redirect = 1'b0;
`ifdef RISCV_FETCH_MISALIGN_EN
    a0 = acc_cnt;
    repeat (8) to_pos();
    to_neg();
    checks++;
    if (bus.o_fetch_misalign !== 1'b1 || bus.o_fetch_misalign_pc !== 32'h102) begin errors++;
      $display("FAIL misalign_flag: got %b/%h want 1/00000102", bus.o_fetch_misalign,
               bus.o_fetch_misalign_pc); end
    checks++; if (acc_cnt - a0 !== 0 || bus.o_if_valid !== 1'b0) begin errors++;
      $display("FAIL misalign_stall: got acc=%0d v=%b want 0/0", acc_cnt - a0,
               bus.o_if_valid); end
    to_pos();
    bus.i_redirect    = 1'b1;
    bus.i_redirect_pc = 32'h0000_0200;
    to_neg();
    got_q.delete();
    to_pos();
    bus.i_redirect = 1'b0;
    to_neg();
    checks++; if (bus.o_fetch_misalign !== 1'b0) begin errors++;
      $display("FAIL misalign_clear: got %b want 0", bus.o_fetch_misalign); end
    to_pos();
    repeat (10) to_pos();
    to_neg();
    checks++;
    if (got_q.size() < 1 || got_q[0].pc !== 32'h200) begin errors++;
      $display("FAIL misalign_resume: got n=%0d want first pc 00000200", got_q.size()); end
`else
    a0 = 0;
    repeat (10) to_pos();
    to_neg();
    checks++;
    if (got_q.size() < 1) begin errors++;
      $display("FAIL align_force_count: got %0d want >=1", got_q.size() + a0);
    end else if (got_q[0].pc !== 32'h100 || got_q[0].instr !== memf(32'h100)) begin errors++;
      $display("FAIL align_force: got %h want 00000100", got_q[0].pc);
    end
`endif
    to_pos();
  endtask

  task automatic test_random();
    logic [31:0] exp, tgt;
    bit          redir, prev;
    int unsigned seen;
    for (int l = 1; l <= 4; l++) begin
      mem_lat   = l;
      ready_rnd = 1'b1;
      apply_reset();
      exp  = RESET_PC;
      prev = 1'b0;
      seen = 0;
      for (int c = 0; c < 300; c++) begin
        redir = !prev && ($urandom_range(0, 15) == 0);
        tgt   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        bus.i_id_ready    = ($urandom_range(0, 2) != 0);
        bus.i_redirect    = redir;
        bus.i_redirect_pc = tgt;
        to_neg();
        while (got_q.size() > 0) begin
          checks++;
          if (got_q[0].pc !== exp || got_q[0].instr !== memf(exp)) begin errors++;
            $display("FAIL random_lat%0d: got %h/%h want %h/%h", l, got_q[0].pc,
                     got_q[0].instr, exp, memf(exp)); end
          exp += 32'd4;
          seen++;
          void'(got_q.pop_front());
        end
        if (redir) exp = tgt;
        prev = redir;
        to_pos();
      end
      bus.i_redirect = 1'b0;
      checks++; if (seen < 20) begin errors++;
        $display("FAIL random_progress_lat%0d: got %0d want >=20", l, seen); end
    end
    ready_rnd      = 1'b0;
    mem_lat        = 1;
    bus.i_id_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    bus.i_id_ready    = 1'b1;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_collide();
    test_async_reset();
    test_wrap();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
